// File: rtl/icb_copy_master.sv
// ICB initiator that copies a block of 32-bit words from a source range to a
// destination range, one read then one write per word, one transaction in flight.
module icb_copy_master #(
    parameter int          LEN_W     = 16,
    parameter int unsigned ADDR_STEP = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CMD = 3'd1,
        RD_RSP = 3'd2,
        WR_CMD = 3'd3,
        WR_RSP = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t           state_r;
    logic [31:0]      src_r;
    logic [31:0]      dst_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;

    logic [31:0]      src_inc_s;
    logic [31:0]      dst_inc_s;
    logic [LEN_W-1:0] cnt_inc_s;

    assign src_inc_s = src_r + 32'(ADDR_STEP);
    assign dst_inc_s = dst_r + 32'(ADDR_STEP);
    assign cnt_inc_s = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};

    // Copy sequencer; every ICB output is a register updated on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            src_r         <= 32'h0000_0000;
            dst_r         <= 32'h0000_0000;
            len_r         <= {LEN_W{1'b0}};
            cnt_r         <= {LEN_W{1'b0}};
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            icb_cmd_valid <= 1'b0;
            icb_cmd_read  <= 1'b0;
            icb_cmd_addr  <= 32'h0000_0000;
            icb_cmd_wdata <= 32'h0000_0000;
            icb_cmd_wmask <= 4'h0;
            icb_rsp_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len != {LEN_W{1'b0}}) begin
                            src_r         <= src_addr;
                            dst_r         <= dst_addr;
                            len_r         <= len;
                            cnt_r         <= {LEN_W{1'b0}};
                            busy          <= 1'b1;
                            icb_cmd_valid <= 1'b1;
                            icb_cmd_read  <= 1'b1;
                            icb_cmd_addr  <= src_addr;
                            icb_cmd_wmask <= 4'h0;
                            state_r       <= RD_CMD;
                        end else begin
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end
                    end
                end
                RD_CMD: begin
                    if (icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        icb_rsp_ready <= 1'b1;
                        state_r       <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (icb_rsp_valid) begin
                        icb_rsp_ready <= 1'b0;
                        if (icb_rsp_err) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end else begin
                            // The write-data register doubles as the word buffer.
                            icb_cmd_wdata <= icb_rsp_rdata;
                            icb_cmd_valid <= 1'b1;
                            icb_cmd_read  <= 1'b0;
                            icb_cmd_addr  <= dst_r;
                            icb_cmd_wmask <= 4'hF;
                            state_r       <= WR_CMD;
                        end
                    end
                end
                WR_CMD: begin
                    if (icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        icb_rsp_ready <= 1'b1;
                        state_r       <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (icb_rsp_valid) begin
                        icb_rsp_ready <= 1'b0;
                        if (icb_rsp_err) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end else begin
                            cnt_r <= cnt_inc_s;
                            src_r <= src_inc_s;
                            dst_r <= dst_inc_s;
                            if (cnt_inc_s == len_r) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= FINISH;
                            end else begin
                                icb_cmd_valid <= 1'b1;
                                icb_cmd_read  <= 1'b1;
                                icb_cmd_addr  <= src_inc_s;
                                icb_cmd_wmask <= 4'h0;
                                state_r       <= RD_CMD;
                            end
                        end
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy          <= 1'b0;
                    icb_cmd_valid <= 1'b0;
                    icb_rsp_ready <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icb_copy_master.sv
// Directed bench for icb_copy_master: an ICB target model with configurable
// ready delay, response latency and error injection, plus logged commands.
module tb_icb_copy_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len = 16'h0;
    logic        busy, done, err;
    logic        icb_cmd_valid, icb_cmd_read, icb_rsp_ready;
    logic        icb_cmd_ready = 1'b0;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid = 1'b0;
    logic [31:0] icb_rsp_rdata = 32'h0;
    logic        icb_rsp_err = 1'b0;

    icb_copy_master #(.LEN_W(16), .ADDR_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Target model knobs and observations
    int ready_delay = 0;
    int rsp_extra = 0;
    int err_rd = -1;
    int err_wr = -1;
    logic [31:0] rd_base = 32'h0;
    int wait_cnt = 0, rsp_cnt = 0, rd_idx = 0, wr_idx = 0;
    int ncmd = 0, stab_err = 0, done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
    logic pend_read = 1'b0;
    logic capt = 1'b0;
    logic [68:0] capt_payload = 69'h0;
    logic        log_read  [0:15];
    logic [31:0] log_addr  [0:15];
    logic [31:0] log_wdata [0:15];
    logic [3:0]  log_wmask [0:15];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ICB target: inputs change on the falling edge, DUT outputs read there too.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                icb_cmd_ready = 1'b0;
                icb_rsp_valid = 1'b0;
                icb_rsp_err   = 1'b0;
                rsp_cnt = 0;
                wait_cnt = 0;
                capt = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                if (icb_cmd_valid) valid_cnt++;
                icb_rsp_valid = 1'b0;
                icb_rsp_err   = 1'b0;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        icb_rsp_valid = 1'b1;
                        if (pend_read) begin
                            icb_rsp_rdata = rd_base + 32'(rd_idx);
                            icb_rsp_err   = (rd_idx == err_rd);
                            rd_idx++;
                        end else begin
                            icb_rsp_rdata = 32'h0;
                            icb_rsp_err   = (wr_idx == err_wr);
                            wr_idx++;
                        end
                    end
                end
                if (icb_cmd_valid && !icb_cmd_ready) begin
                    if (!capt) begin
                        capt_payload = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
                        capt = 1'b1;
                    end else if (capt_payload !== {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask}) begin
                        stab_err++;
                    end
                    if (wait_cnt >= ready_delay) begin
                        icb_cmd_ready = 1'b1;
                        if (ncmd < 16) begin
                            log_read[ncmd]  = icb_cmd_read;
                            log_addr[ncmd]  = icb_cmd_addr;
                            log_wdata[ncmd] = icb_cmd_wdata;
                            log_wmask[ncmd] = icb_cmd_wmask;
                        end
                        ncmd++;
                        pend_read = icb_cmd_read;
                        rsp_cnt = 1 + rsp_extra;
                        wait_cnt = 0;
                        capt = 1'b0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    icb_cmd_ready = 1'b0;
                end
            end
        end
    end

    task automatic clr_log();
        #2;
        ncmd = 0; stab_err = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        rd_idx = 0; wr_idx = 0; err_rd = -1; err_wr = -1;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic chk_cmd(input int i, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        chk($sformatf("cmd%0d", i),
            {log_read[i], log_addr[i], (rd ? 32'h0 : log_wdata[i]), log_wmask[i]},
            {rd, a, (rd ? 32'h0 : d), m});
    endtask

    task automatic verify_copy(input logic [31:0] s, input logic [31:0] d,
                               input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            chk_cmd(2*k,   1'b1, s + 32'(4*k), 32'h0, 4'h0);
            chk_cmd(2*k+1, 1'b0, d + 32'(4*k), base + 32'(k), 4'hF);
        end
    endtask

    int cyc;
    int found;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs",
            {busy, done, err, icb_cmd_valid, icb_cmd_read, icb_cmd_addr,
             icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready}, 96'h0);

        // Basic zero-wait copy of three words
        clr_log(); ready_delay = 0; rsp_extra = 0; rd_base = 32'hA0;
        start_copy(32'h1000_0010, 32'h1000_0030, 16'd3);
        wait_done("basic", cyc);
        chk("basic_latency", cyc, 12);
        chk("basic_busy_in_finish", busy, 1'b0);
        chk("basic_err", err, 1'b0);
        @(negedge clk);
        chk("basic_done_one_cycle", done, 1'b0);
        #2;
        chk("basic_ncmd", ncmd, 6);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_busy_cycles", busy_cnt, 12);
        verify_copy(32'h1000_0010, 32'h1000_0030, 32'hA0, 3);

        // Backpressure on every command plus 2-cycle response latency
        clr_log(); ready_delay = 5; rsp_extra = 1; rd_base = 32'hB0;
        start_copy(32'h0000_0200, 32'h0000_0300, 16'd3);
        wait_done("bp", cyc);
        #2;
        chk("bp_ncmd", ncmd, 6);
        chk("bp_stable", stab_err, 0);
        chk("bp_valid_cycles", valid_cnt, 36);
        chk("bp_err", err, 1'b0);
        verify_copy(32'h0000_0200, 32'h0000_0300, 32'hB0, 3);

        // Zero-length copy
        clr_log(); ready_delay = 0; rsp_extra = 0;
        start_copy(32'h1234_5678, 32'h8765_4320, 16'd0);
        wait_done("len0", cyc);
        chk("len0_latency", cyc, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("len0_no_cmd", valid_cnt, 0);
        chk("len0_busy", busy_cnt, 0);
        chk("len0_done_cnt", done_cnt, 1);

        // Read error on the second word
        clr_log(); err_rd = 1; rd_base = 32'h50;
        start_copy(32'h0000_1000, 32'h0000_2000, 16'd4);
        wait_done("rderr", cyc);
        chk("rderr_err_at_done", err, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        chk("rderr_ncmd", ncmd, 3);
        chk_cmd(1, 1'b0, 32'h0000_2000, 32'h50, 4'hF);
        chk("rderr_err_sticky", err, 1'b1);
        chk("rderr_done_cnt", done_cnt, 1);

        clr_log(); rd_base = 32'hC0;
        start_copy(32'h3000_0000, 32'h3000_0100, 16'd1);
        chk("restart_err_cleared", err, 1'b0);
        wait_done("restart", cyc);
        #2;
        chk("restart_ncmd", ncmd, 2);
        chk("restart_err", err, 1'b0);
        verify_copy(32'h3000_0000, 32'h3000_0100, 32'hC0, 1);

        // Address wrap, with a start pulse while busy that must be ignored
        clr_log(); rd_base = 32'hD0;
        start_copy(32'hFFFF_FFFC, 32'h2000_0000, 16'd2);
        repeat (2) @(negedge clk);
        start = 1'b1; src_addr = 32'h5000_0000; dst_addr = 32'h6000_0000; len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("wrap", cyc);
        repeat (4) @(negedge clk);
        #2;
        chk("wrap_ncmd", ncmd, 4);
        chk("wrap_idle", busy, 1'b0);
        verify_copy(32'hFFFF_FFFC, 32'h2000_0000, 32'hD0, 2);

        // Reset while a write command is pending
        clr_log(); ready_delay = 2; rd_base = 32'hE0;
        start_copy(32'h4000_0000, 32'h4000_0040, 16'd3);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            if (icb_cmd_valid && !icb_cmd_read) found = 1;
            else @(negedge clk);
        end
        chk("rstmid_wrcmd_found", found, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {icb_cmd_valid, busy, done}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_idle", busy, 1'b0);

        clr_log(); ready_delay = 0; rd_base = 32'hF0;
        start_copy(32'h4000_0100, 32'h4000_0200, 16'd2);
        wait_done("post_rst", cyc);
        #2;
        chk("post_rst_ncmd", ncmd, 4);
        chk("post_rst_err", err, 1'b0);
        verify_copy(32'h4000_0100, 32'h4000_0200, 32'hF0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icb_copy_master.md
Name: icb_copy_master

Overview:
- ICB initiator (master) that copies a block of 32-bit words from one ICB address range to another.
- Word by word: read source, then write destination.
- Sits between a control source (CPU-written config or local sequencer) and the ICB fabric. Drives the accelerator's ICB slave register/SRAM window or any other ICB target.
- One outstanding transaction at a time; never overlaps commands.

Parameters:
LEN_W, 16, width of the word-count input len
ADDR_STEP, 4, byte increment applied to src/dst addresses after each word

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a copy; sampled only in IDLE
src_addr  in  32  source byte address, sampled with start
dst_addr  in  32  destination byte address, sampled with start
len  in  LEN_W  number of words to copy, sampled with start
busy  out  1  high while a copy is in progress
done  out  1  one-cycle pulse at completion (normal or error)
err  out  1  sticky error flag, cleared when next start is accepted
icb_cmd_valid  out  1  command valid
icb_cmd_ready  in  1  command accepted by target
icb_cmd_read  out  1  1=read, 0=write
icb_cmd_addr  out  32  command byte address
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  byte enables, 4'hF for writes, 4'h0 for reads
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  master ready for response
icb_rsp_rdata  in  32  read data
icb_rsp_err  in  1  response error

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs 0: busy, done, err, icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready.
  - Internal counters and address registers 0.
  - Reset mid-copy aborts immediately; no done pulse.
- States: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, FINISH.
- IDLE:
  - start=1 and len!=0: latch src/dst/len, clear cnt and err, go to RD_CMD.
  - start=1 and len==0: clear err, go to FINISH (no ICB traffic).
- RD_CMD:
  - Outputs: cmd_valid=1, read=1, addr=cur_src, wmask=0.
  - On cmd_valid & cmd_ready: cmd_valid drops next cycle, go to RD_RSP.
- RD_RSP:
  - rsp_ready=1.
  - On rsp_valid: capture rdata into data buffer.
  - If rsp_err: set err, go to FINISH. Else go to WR_CMD.
- WR_CMD:
  - Outputs: cmd_valid=1, read=0, addr=cur_dst, wdata=buffer, wmask=4'hF.
  - On handshake: go to WR_RSP.
- WR_RSP:
  - rsp_ready=1.
  - On rsp_valid with rsp_err: set err, go to FINISH.
  - Else: cnt+1, cur_src+=ADDR_STEP, cur_dst+=ADDR_STEP.
  - If cnt+1==len go to FINISH, else go to RD_CMD.
- FINISH: done=1 for exactly one cycle, then IDLE.
- busy=1 in RD_CMD..WR_RSP; 0 in IDLE and FINISH.
- Command payload (read, addr, wdata, wmask) is registered and held stable while cmd_valid=1 and cmd_ready=0.
  - cmd_valid never deasserts before the handshake.
- cmd_ready may be high before cmd_valid; a handshake occurs only when both are high in the same cycle.
- rsp_ready=0 outside RD_RSP/WR_RSP; rsp_valid in other states is ignored.
- Latency per word with a zero-wait target: 4 cycles (cmd, rsp, cmd, rsp).
  - Must tolerate targets that assert cmd_ready one cycle after cmd_valid, and read responses 2 cycles after the handshake.
- Address arithmetic is 32-bit modulo; wrap at 32'hFFFF_FFFC -> 32'h0000_0000 is legal and not an error.
- err is sticky until the next accepted start; done still pulses on error.
- start outside IDLE is ignored; inputs are not resampled.
- A write-response error on word k aborts the copy: cnt stays k, no further commands.

Test Plan:
- Reset mid-copy: assert rst during WR_CMD -> same cycle cmd_valid=0, busy=0, done never pulses; after release, a new copy completes normally.
- Basic copy: src=0x1000_0010, dst=0x1000_0030, len=3, target returns 0xA0,0xA1,0xA2 -> reads at 0x...10/14/18, writes at 0x...30/34/38 with matching data and wmask=F; done pulses once; err=0.
- Backpressure: target holds cmd_ready low 5 cycles on each command -> addr/wdata/read stable throughout, exactly one handshake per command, 6 total ICB commands for len=3.
- len=0: start -> no cmd_valid ever asserted, done pulses on the cycle after start, busy stays 0.
- Error abort: len=4, rsp_err=1 on the 2nd read response -> exactly 1 write issued, err=1, done pulses; next start with len=1 clears err and copies normally.
- Wrap and ignored start: src=0xFFFF_FFFC, len=2 -> second read at 0x0000_0000; start pulsed while busy with other args -> ignored, copy uses the original parameters.
